// File: rtl/loader_pkg.sv
// Shared types and control-word constants for the program loader.
// Bit map: [14]Cp [13]Ep [12]Lp [11]nLma [10]nLmd [9]nCE [8]nLr [7]nLi [6]nEi [5]nLa [4]Ea [3]sub [2]Eu [1]nLb [0]nLo.
package loader_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_HOLD,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int CP_BIT   = 14;
    localparam int EP_BIT   = 13;
    localparam int LP_BIT   = 12;
    localparam int NLMA_BIT = 11;
    localparam int NLMD_BIT = 10;
    localparam int NCE_BIT  = 9;
    localparam int NLR_BIT  = 8;
    localparam int NLI_BIT  = 7;
    localparam int NEI_BIT  = 6;
    localparam int NLA_BIT  = 5;
    localparam int EA_BIT   = 4;
    localparam int SUB_BIT  = 3;
    localparam int EU_BIT   = 2;
    localparam int NLB_BIT  = 1;
    localparam int NLO_BIT  = 0;

    localparam logic [14:0] IDLE_WORD  = 15'h0FE3;
    localparam logic [14:0] ADDR_WORD  = 15'h07E3;
    localparam logic [14:0] DATA_WORD  = 15'h0BE3;
    localparam logic [14:0] WRITE_WORD = 15'h0EE3;

endpackage

// File: rtl/loader_ctrl_mux.sv
// Chooses between the CPU control word and the loader-generated word.
module loader_ctrl_mux #(
    parameter int CTRL_W = 15
) (
    input  logic              sel_loader,
    input  logic [CTRL_W-1:0] cpu_ctrl,
    input  logic [CTRL_W-1:0] loader_ctrl,
    output logic [CTRL_W-1:0] ctrl_out
);

    assign ctrl_out = sel_loader ? loader_ctrl : cpu_ctrl;

endmodule

// File: rtl/program_loader_arbiter.sv
// Program-load arbiter: holds the CPU and writes host bytes into RAM.
// Define LOADER_CHECKSUM_EN to build the running byte checksum.
module program_loader_arbiter
    import loader_pkg::*;
#(
    parameter int RAM_DEPTH = 16,
    parameter int ADDR_W    = 4,
    parameter int CTRL_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [CTRL_W-1:0] cpu_ctrl_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic [7:0]        checksum
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     count;
    logic [7:0]          byte_q;
    logic [CTRL_W-1:0]   ldr_word;
    logic                last;
    logic                start;
    logic                take;

    assign last      = (addr == ADDR_W'(RAM_DEPTH - 1));
    assign start     = (state == S_RUN) && load_req;
    assign take      = (state == S_WAIT) && data_valid;
    assign cpu_rst_n = (state == S_RUN);
    assign load_count = count;

    always_comb begin
        state_nx   = state;
        ldr_word   = CTRL_W'(IDLE_WORD);
        bus_out    = '0;
        bus_oe     = 1'b0;
        data_ready = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            S_RUN: begin
                if (load_req) state_nx = S_HOLD;
            end
            S_HOLD: state_nx = S_WAIT;
            S_WAIT: begin
                data_ready = 1'b1;
                if (data_valid)     state_nx = S_ADDR;
                else if (!load_req) state_nx = S_DONE;
            end
            S_ADDR: begin
                bus_out  = 8'(addr);
                bus_oe   = 1'b1;
                ldr_word = CTRL_W'(ADDR_WORD);
                state_nx = S_DATA;
            end
            S_DATA: begin
                bus_out  = byte_q;
                bus_oe   = 1'b1;
                ldr_word = CTRL_W'(DATA_WORD);
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                ldr_word = CTRL_W'(WRITE_WORD);
                state_nx = (last || !load_req) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                load_done = 1'b1;
                state_nx  = S_RUN;
            end
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RUN;
            addr   <= '0;
            count  <= '0;
            byte_q <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr  <= '0;
                count <= '0;
            end
            if (take) byte_q <= data_in;
            if (state == S_WRITE) begin
                addr <= addr + 1'b1;
                if (count != (ADDR_W+1)'(RAM_DEPTH)) count <= count + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start) begin
            sum_q <= '0;
        end else if (take) begin
            sum_q <= sum_q + data_in;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

    loader_ctrl_mux #(
        .CTRL_W(CTRL_W)
    ) u_mux (
        .sel_loader (state != S_RUN),
        .cpu_ctrl   (cpu_ctrl_in),
        .loader_ctrl(ldr_word),
        .ctrl_out   (ctrl_out)
    );

endmodule

// File: tb/tb_program_loader_arbiter.sv
// Directed and randomized bench for program_loader_arbiter with a
// byte-level reference model and a MAR/RAM datapath model.
module tb_program_loader_arbiter;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [14:0] cpu_ctrl_in;
    logic [14:0] ctrl_out;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic        cpu_rst_n;
    logic        load_done;
    logic [4:0]  load_count;
    logic [7:0]  checksum;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] src[16];
    logic [7:0] ref_ram[16];
    logic [7:0] ref_sum;

    logic [3:0] mar;
    logic [7:0] mdr;
    logic [7:0] tb_ram[16];

    program_loader_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .cpu_ctrl_in(cpu_ctrl_in),
        .ctrl_out   (ctrl_out),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_count (load_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: MAR, RAM data latch and RAM driven by the loader word.
    always @(posedge clk) begin
        if (rst_n && !cpu_rst_n) begin
            if (!ctrl_out[11]) mar <= bus_out[3:0];
            if (!ctrl_out[10]) mdr <= bus_out;
            if (!ctrl_out[8])  tb_ram[mar] <= mdr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_run();
        tick();
        chk("run_rst", cpu_rst_n, 1);
        chk("run_ctrl", ctrl_out, cpu_ctrl_in);
        chk("run_oe", bus_oe, 0);
        chk("run_done", load_done, 0);
        chk("run_rdy", data_ready, 0);
    endtask

    // drop_mode: 0 drop after last byte, 1 drop with last byte, 2 drop in ADDR
    task automatic do_session(input int n, input bit rnd, input int drop_mode);
        int  k;
        int  budget;
        bit  fin;
        bit  took;
        logic [7:0] exp_sum;
        k = 0;
        budget = 0;
        fin = 0;
        ref_sum = 8'h00;
        load_req = 1'b1;
        data_valid = 1'b0;
        tick();
        chk("hold_ctrl", ctrl_out, 15'h0FE3);
        chk("hold_rst", cpu_rst_n, 0);
        chk("hold_rdy", data_ready, 0);
        chk("hold_cnt", load_count, 0);
        tick();
        while (!fin) begin
            chk("wait_rdy", data_ready, 1);
            chk("wait_ctrl", ctrl_out, 15'h0FE3);
            chk("wait_oe", bus_oe, 0);
            took = 0;
            if (k < n && (!rnd || $urandom_range(0, 2) != 0)) begin
                data_in = src[k];
                data_valid = 1'b1;
                took = 1;
                if (drop_mode == 1 && k == n - 1) load_req = 1'b0;
            end else begin
                data_valid = 1'b0;
                data_in = 8'($urandom);
                if (k >= n) load_req = 1'b0;
            end
            tick();
            if (took) begin
                ref_ram[k] = src[k];
                ref_sum = ref_sum + src[k];
                data_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                data_in = 8'($urandom);
                chk("addr_ctrl", ctrl_out, 15'h07E3);
                chk("addr_bus", bus_out, k);
                chk("addr_oe", bus_oe, 1);
                chk("addr_rdy", data_ready, 0);
                if (drop_mode == 2 && k == n - 1) load_req = 1'b0;
                tick();
                chk("data_ctrl", ctrl_out, 15'h0BE3);
                chk("data_bus", bus_out, src[k]);
                chk("data_oe", bus_oe, 1);
                tick();
                chk("wr_ctrl", ctrl_out, 15'h0EE3);
                chk("wr_oe", bus_oe, 0);
                chk("wr_rst", cpu_rst_n, 0);
                k++;
                tick();
                if (k == 16 || !load_req) fin = 1;
            end else if (!load_req) begin
                fin = 1;
            end
            budget++;
            if (!fin && budget > 300) begin
                n_assert++;
                n_fail++;
                $error("FAIL session_timeout observed=%0d expected<=300", budget);
                fin = 1;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        exp_sum = ref_sum;
`else
        exp_sum = 8'h00;
`endif
        chk("done_pulse", load_done, 1);
        chk("done_ctrl", ctrl_out, 15'h0FE3);
        chk("done_rst", cpu_rst_n, 0);
        chk("done_rdy", data_ready, 0);
        chk("done_cnt", load_count, k);
        chk("done_sum", checksum, exp_sum);
        for (int i = 0; i < k; i++) chk($sformatf("ram%0d", i), tb_ram[i], ref_ram[i]);
    endtask

    initial begin
        rst_n = 1'b0;
        load_req = 1'b0;
        data_valid = 1'b0;
        data_in = 8'h00;
        cpu_ctrl_in = 15'h5A5A;
        #1;
        chk("rst_ctrl", ctrl_out, 15'h5A5A);
        chk("rst_oe", bus_oe, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_cpu", cpu_rst_n, 1);
        chk("rst_rdy", data_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_cnt", load_count, 0);
        chk("rst_sum", checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cpu_ctrl_in = 15'h1234;
        #1;
        chk("pass_ctrl", ctrl_out, 15'h1234);
        cpu_ctrl_in = 15'h5A5A;
        #1;
        chk("pass_ctrl2", ctrl_out, 15'h5A5A);

        src[0] = 8'h1E;
        src[1] = 8'h2F;
        do_session(2, 0, 0);
        expect_run();

        src[0] = 8'hF0;
        src[1] = 8'h20;
        do_session(2, 0, 0);
        expect_run();

        for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
        do_session(16, 0, 0);
        data_valid = 1'b1;
        data_in = 8'hAA;
        #1;
        chk("b17_rdy", data_ready, 0);
        tick();
        chk("again_run_rst", cpu_rst_n, 1);
        chk("again_run_rdy", data_ready, 0);
        chk("again_run_ctrl", ctrl_out, cpu_ctrl_in);
        tick();
        chk("again_hold_rst", cpu_rst_n, 0);
        chk("again_hold_ctrl", ctrl_out, 15'h0FE3);
        chk("again_hold_cnt", load_count, 0);
        chk("again_hold_rdy", data_ready, 0);
        load_req = 1'b0;
        data_valid = 1'b0;
        tick();
        chk("again_wait_rdy", data_ready, 1);
        tick();
        chk("again_done", load_done, 1);
        chk("again_done_cnt", load_count, 0);
        expect_run();

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
            cpu_ctrl_in = 15'($urandom);
            do_session($urandom_range(1, 15), 1, r % 3);
            expect_run();
        end

        load_req = 1'b1;
        tick();
        tick();
        data_valid = 1'b1;
        data_in = 8'h77;
        tick();
        data_valid = 1'b0;
        tick();
        chk("pre_rst_oe", bus_oe, 1);
        chk("pre_rst_bus", bus_out, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", bus_oe, 0);
        chk("arst_bus", bus_out, 0);
        chk("arst_cpu", cpu_rst_n, 1);
        chk("arst_ctrl", ctrl_out, cpu_ctrl_in);
        chk("arst_rdy", data_ready, 0);
        chk("arst_cnt", load_count, 0);
        @(negedge clk);
        load_req = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_cpu", cpu_rst_n, 1);

        src[0] = 8'h3C;
        do_session(1, 0, 0);
        expect_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader_arbiter.md
Name: program_loader_arbiter

Overview:
- Arbitrates the 15-bit datapath control word and the shared 8-bit bus between the CPU control_block and an external program-load port.
- In load mode: holds the CPU in reset, writes host-supplied bytes into the 16-byte RAM through the MAR/RAM control lines, then hands control back to the CPU.
- Placed between control_block and the datapath in the CPU top level.

Parameters:
- RAM_DEPTH, 16, number of RAM bytes; the address wraps after RAM_DEPTH-1.
- ADDR_W, 4, width of the MAR/RAM address (clog2 of RAM_DEPTH).
- CTRL_W, 15, width of the control word.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req  in  1  high requests program-load mode; level-sensitive.
- data_in  in  8  byte from the host.
- data_valid  in  1  host byte valid.
- data_ready  out  1  loader accepts a byte.
- cpu_ctrl_in  in  CTRL_W  control word from control_block.
- ctrl_out  out  CTRL_W  control word to the datapath.
- bus_out  out  8  value the loader drives onto the bus.
- bus_oe  out  1  loader drives the bus.
- cpu_rst_n  out  1  active-low hold for control_block and the program counter.
- load_done  out  1  one-cycle pulse when loading ends.
- load_count  out  ADDR_W+1  number of bytes written in the current/last session.
- checksum  out  8  see Optional Feature.

Behaviour:
- Control-word bit map: [14]Cp [13]Ep [12]Lp [11]nLma [10]nLmd [9]nCE [8]nLr [7]nLi [6]nEi [5]nLa [4]Ea [3]sub [2]Eu [1]nLb [0]nLo.
- IDLE_WORD = 0x0FE3 (every control signal deasserted).
- States and outputs:
  - RUN: ctrl_out = cpu_ctrl_in (combinational pass-through); bus_oe=0; cpu_rst_n=1.
  - HOLD: one cycle; ctrl_out=IDLE_WORD; cpu_rst_n=0; addr counter cleared; load_count cleared.
  - WAIT: data_ready=1; ctrl_out=IDLE_WORD.
  - ADDR: bus_out=addr zero-extended; bus_oe=1; ctrl_out=0x07E3 (nLma low).
  - DATA: bus_out=captured byte; bus_oe=1; ctrl_out=0x0BE3 (nLmd low).
  - WRITE: bus_oe=0; ctrl_out=0x0EE3 (nLr low); RAM writes its data latch at the MAR address.
  - DONE: one cycle; ctrl_out=IDLE_WORD; load_done=1; cpu_rst_n=0.
- cpu_rst_n is 0 in every state except RUN.
- Transitions:
  - RUN -> HOLD when load_req=1.
  - HOLD -> WAIT.
  - WAIT -> ADDR on data_valid & data_ready; the byte is captured on that edge.
  - WAIT -> DONE when load_req=0 and data_valid=0.
  - ADDR -> DATA -> WRITE unconditionally.
  - WRITE -> DONE if addr==RAM_DEPTH-1 or load_req=0; else WAIT with addr+1 and load_count+1.
  - WRITE -> DONE also increments load_count.
  - DONE -> RUN.
- Handshake: a transfer occurs only when data_valid and data_ready are both high. data_ready is high only in WAIT, so at most one byte is in flight. Write throughput is one byte per 4 cycles.
- WAIT with both data_valid=1 and load_req=0: the byte is accepted and written; the exit is taken after WRITE.
- load_req dropping during ADDR/DATA/WRITE: the current write completes, then DONE.
- Wrap-around: the 16th byte ends the session. load_count saturates at RAM_DEPTH (5 bits, value 16).
- load_req held high after DONE: RUN for exactly one cycle, then HOLD again, starting a new session from address 0.
- Reset (async, any state):
  - state=RUN; addr=0; load_count=0; captured byte=0; checksum=0.
  - data_ready=0, bus_oe=0, bus_out=0, load_done=0, cpu_rst_n=1.
  - ctrl_out follows cpu_ctrl_in.
- Top-level integration: bus_oe must be ORed into the bus idle-drive enable. The loader never drives the bus while in RUN.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: checksum is an 8-bit modulo-256 sum of every byte written, cleared in HOLD and updated on the WAIT->ADDR transfer.
- Undefined: checksum is tied to 8'h00 and the adder is not built.

Decomposition:
- Package loader_pkg holds:
  - state enum: RUN, HOLD, WAIT, ADDR, DATA, WRITE, DONE.
  - control-bit index constants (CP_BIT ... NLO_BIT).
  - IDLE_WORD, ADDR_WORD, DATA_WORD, WRITE_WORD.
- One sub-module, loader_ctrl_mux: selects between cpu_ctrl_in and the loader word. The FSM and counters stay in the top of the block.

Test Plan:
- Reset then cpu_ctrl_in=0x5A5A with load_req=0 -> ctrl_out=0x5A5A same cycle; bus_oe=0, cpu_rst_n=1, data_ready=0.
- load_req=1; bytes 0x1E then 0x2F sent with data_valid held; then load_req=0 -> ctrl_out sequence HOLD, WAIT, 0x07E3/bus=0x00, 0x0BE3/bus=0x1E, 0x0EE3, then repeated for address 0x01 with bus=0x2F; load_done pulse; load_count=2; RAM[0]=0x1E, RAM[1]=0x2F.
- 16 consecutive bytes with load_req held high -> DONE after the 16th WRITE with no further data_ready; load_count=16; the 17th byte is not accepted; after DONE, one RUN cycle with cpu_rst_n=1, then HOLD.
- data_valid toggled randomly in WAIT -> byte captured only on cycles with data_valid&data_ready; the write count matches accepted bytes.
- rst_n asserted during the DATA state -> bus_oe=0, cpu_rst_n=1, and ctrl_out passes cpu_ctrl_in immediately, before any clock edge.
- LOADER_CHECKSUM_EN defined, bytes 0xF0, 0x20 -> checksum=0x10. Undefined -> checksum=0x00.
